// File: rtl/seq_add_pkg.sv
// Shared types and defaults for the byte-serial add/subtract controller.
package seq_add_pkg;

  localparam int unsigned NBYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_add_ctrl_rca.sv
// 8-bit ripple-carry adder: the single shared datapath adder of seq_add_ctrl.
module RippleCarryAdder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
);

  logic [8:0] carry;

  // Chain of full adders, carry rippling from bit 0 upward.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < 8; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = carry[8];

endmodule

// File: rtl/seq_add_ctrl.sv
// Byte-serial add/subtract: one byte per cycle through a shared 8-bit adder,
// with carry, signed overflow and a single-cycle done pulse.
module seq_add_ctrl
  import seq_add_pkg::*;
#(
  parameter  int unsigned NBYTES = NBYTES_DEFAULT,
  localparam int unsigned W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         overflow
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t         state;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           sub_reg;

  logic [7:0]     add_in1;
  logic [7:0]     add_in2;
  logic           add_cin;
  logic [7:0]     add_sum;
  logic           add_cout;
  logic           last_byte;
  logic           ovf_next;

  // Operand byte select; subtraction is a + ~b + 1 with the +1 as the first carry-in.
  always_comb begin
    add_in1   = a_reg[8*32'(idx) +: 8];
    add_in2   = b_reg[8*32'(idx) +: 8] ^ {8{sub_reg}};
    add_cin   = (idx == '0) ? sub_reg : carry;
    last_byte = (idx == IW'(NBYTES - 1));
    ovf_next  = (a_reg[W-1] == (b_reg[W-1] ^ sub_reg)) && (add_sum[7] != a_reg[W-1]);
  end

  RippleCarryAdder_8bit u_rca (
    .a     (add_in1),
    .b     (add_in2),
    .c_in  (add_cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sub_reg  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          result[8*32'(idx) +: 8] <= add_sum;
          carry                   <= add_cout;
          if (last_byte) begin
            c_out    <= add_cout;
            overflow <= ovf_next;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Directed and random checks of seq_add_ctrl against an arithmetic reference model.
module tb_seq_add_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;

  int     checks = 0;
  int     fails  = 0;
  longint cyc    = 0;
  longint done_cyc;
  longint prev_done_cyc;

  seq_add_ctrl #(.NBYTES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] full;
    longint     sx, sy, sres;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r    = x - y;
      c    = (x >= y);
      sres = sx - sy;
    end else begin
      full = {1'b0, x} + {1'b0, y};
      r    = full[W-1:0];
      c    = full[W];
      sres = sx + sy;
    end
    v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
  endtask

  // Issues one operation, checks latency and outputs; returns in the IDLE cycle after done.
  task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    logic [W-1:0] er;
    logic         ec, ev;
    int           n;
    model(s, x, y, er, ec, ev);
    start = 1'b1; sub = s; a = x; b = y;
    tick();
    start = 1'b0; sub = 1'($urandom); a = $urandom; b = $urandom;
    n = 1;
    while (!done && n < 20) begin
      chk({tag, " busy_in_add"}, 32'(busy), 32'd1);
      tick();
      n++;
    end
    done_cyc = cyc;
    chk({tag, " latency"}, 32'(n), 32'd5);
    chk({tag, " result"}, result, er);
    chk({tag, " c_out"}, 32'(c_out), 32'(ec));
    chk({tag, " overflow"}, 32'(overflow), 32'(ev));
    chk({tag, " busy_in_done"}, 32'(busy), 32'd1);
    tick();
    chk({tag, " done_cleared"}, 32'(done), 32'd0);
    chk({tag, " busy_cleared"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] er;
    logic         ec, ev;
    int           pulses;
    int           done_n;
    logic [W-1:0] cap_result;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick();
    tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset c_out", 32'(c_out), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Boundary vectors.
    run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, "add_ff_1");
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap");
    run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");
    run_op(1'b1, 32'h0000_0005, 32'h0000_0007, "sub_5_7");
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, "sub_ovf");

    // Start re-asserted during ADD must be ignored.
    model(1'b0, 32'h1234_5678, 32'h1111_1111, er, ec, ev);
    start = 1'b1; sub = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
    tick();
    start = 1'b0;
    pulses = 0; done_n = 0; cap_result = '0;
    for (int n = 1; n <= 10; n++) begin
      if (done) begin
        pulses++;
        done_n = n;
        cap_result = result;
      end
      if (n == 2) begin
        start = 1'b1; sub = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
      end
      if (n == 4) start = 1'b0;
      tick();
    end
    chk("restart_ignored pulses", 32'(pulses), 32'd1);
    chk("restart_ignored latency", 32'(done_n), 32'd5);
    chk("restart_ignored result", cap_result, er);

    // Reset in the second ADD cycle aborts, then an immediate new start works.
    start = 1'b1; sub = 1'b0; a = 32'hFFFF_FFFF; b = 32'h0000_FFFF;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort done", 32'(done), 32'd0);
    rst = 1'b0;
    run_op(1'b0, 32'd1, 32'd2, "after_abort");

    // Reset wins over start.
    rst = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9;
    tick();
    chk("rst_priority busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();

    // Back-to-back: second start in the IDLE cycle right after done.
    run_op(1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5B, "b2b_first");
    prev_done_cyc = done_cyc;
    run_op(1'b1, 32'h0000_1000, 32'h0000_2000, "b2b_second");
    chk("b2b done spacing", 32'(done_cyc - prev_done_cyc), 32'd6);

    // Random operations, also issued back-to-back.
    for (int i = 0; i < 24; i++) begin
      logic         rs;
      logic [W-1:0] ra, rb;
      rs = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) ra = {1'b1, 31'($urandom_range(0, 3))};
      if (i % 6 == 1) rb = 32'hFFFF_FFFF;
      run_op(rs, ra, rb, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
